// File: rtl/pipe_mem_pkg.sv
// Shared types for the unified-memory port arbiter.
// Used by the arbiter top and its starvation counter.
package pipe_mem_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BUSY_I,
    ARB_BUSY_D
  } arb_state_e;

  typedef enum logic {
    OWN_IF,
    OWN_DM
  } arb_owner_e;

  localparam int ARB_ADDR_W = 32;
  localparam int ARB_DATA_W = 32;
  localparam int ARB_STARVE = 4;

endpackage

// File: rtl/mem_port_arbiter_starve_ctr.sv
// Saturating count of data grants taken while fetch waits.
// Clear wins over increment; atLimit hands the next grant to fetch.
module arb_starve_ctr
  import pipe_mem_pkg::*;
#(
  parameter int LIMIT = ARB_STARVE
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic atLimit
);

  localparam int W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] MAX = W'(LIMIT);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && cnt != MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign atLimit = (cnt == MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-ported memory shared by fetch and load/store stages.
// Data has priority; fetch wins once the starve window fills.
module mem_port_arbiter
  import pipe_mem_pkg::*;
#(
  parameter int ADDR_W       = ARB_ADDR_W,
  parameter int DATA_W       = ARB_DATA_W,
  parameter int STARVE_LIMIT = ARB_STARVE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_f,
  output logic              stall_m
);

  arb_state_e state;
  arb_owner_e owner;
  logic       idle;
  logic       anyGnt;
  logic       atLimit;

  assign idle = (state == ARB_IDLE);

  // Fetch only overrides data once the starve window is full.
  assign owner = (dm_req && !(atLimit && if_req)) ? OWN_DM : OWN_IF;

  assign dm_gnt = rst & idle & dm_req & (owner == OWN_DM);
  assign if_gnt = rst & idle & if_req & (owner == OWN_IF);
  assign anyGnt = if_gnt | dm_gnt;

  assign stall_f = rst & if_req & ~if_rvalid;
  assign stall_m = rst & dm_req & ~dm_rvalid;

  arb_starve_ctr #(
    .LIMIT(STARVE_LIMIT)
  ) uStarve (
    .clk    (clk),
    .rst    (rst),
    .inc    (dm_gnt & if_req),
    .clr    (if_gnt | ~if_req),
    .atLimit(atLimit)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ARB_IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      dm_rvalid <= 1'b0;
      dm_rdata  <= '0;
    end else begin
      if_rvalid <= 1'b0;
      dm_rvalid <= 1'b0;
      unique case (state)
        ARB_IDLE: begin
          if (anyGnt) begin
            mem_req <= 1'b1;
            if (owner == OWN_DM) begin
              state     <= ARB_BUSY_D;
              mem_we    <= dm_we;
              mem_addr  <= dm_addr;
              mem_wdata <= dm_wdata;
            end else begin
              state     <= ARB_BUSY_I;
              mem_we    <= 1'b0;
              mem_addr  <= if_addr;
              mem_wdata <= '0;
            end
          end
        end
        ARB_BUSY_I: begin
          if (mem_ready) begin
            state     <= ARB_IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            if_rdata  <= mem_rdata;
            if_rvalid <= 1'b1;
          end
        end
        ARB_BUSY_D: begin
          if (mem_ready) begin
            state     <= ARB_IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            dm_rvalid <= 1'b1;
            if (!mem_we) begin
              dm_rdata <= mem_rdata;
            end
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter.
// Inputs change 1ns after posedge; outputs checked 2ns after.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        stall_f;
  logic        stall_m;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .STARVE_LIMIT(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_gnt   (if_gnt),
    .if_rvalid(if_rvalid),
    .if_rdata (if_rdata),
    .dm_req   (dm_req),
    .dm_we    (dm_we),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_gnt   (dm_gnt),
    .dm_rvalid(dm_rvalid),
    .dm_rdata (dm_rdata),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ready(mem_ready),
    .mem_rdata(mem_rdata),
    .stall_f  (stall_f),
    .stall_m  (stall_m)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic edgeIn();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  byte grants[6];
  int  nG;

  initial begin
    rst       = 1'b0;
    if_req    = 1'b1;
    if_addr   = 32'h0;
    dm_req    = 1'b1;
    dm_we     = 1'b0;
    dm_addr   = 32'h0;
    dm_wdata  = 32'h0;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;

    // reset held with both requests active
    for (int i = 0; i < 3; i++) begin
      edgeIn();
      settle();
      chk("rst_if_gnt", {31'd0, if_gnt}, 32'd0);
      chk("rst_dm_gnt", {31'd0, dm_gnt}, 32'd0);
      chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
      chk("rst_stall_f", {31'd0, stall_f}, 32'd0);
      chk("rst_stall_m", {31'd0, stall_m}, 32'd0);
      chk("rst_rvalids", {30'd0, if_rvalid, dm_rvalid}, 32'd0);
    end
    chk("rst_dm_rdata", dm_rdata, 32'd0);

    edgeIn();
    rst    = 1'b1;
    if_req = 1'b0;
    dm_req = 1'b0;

    // single fetch, ready on 3rd mem_req cycle
    edgeIn();
    if_req  = 1'b1;
    if_addr = 32'h10;
    settle();
    chk("f_c0_gnt", {31'd0, if_gnt}, 32'd1);
    chk("f_c0_stall", {31'd0, stall_f}, 32'd1);
    chk("f_c0_memreq", {31'd0, mem_req}, 32'd0);
    edgeIn();
    settle();
    chk("f_c1_memreq", {31'd0, mem_req}, 32'd1);
    chk("f_c1_addr", mem_addr, 32'h10);
    chk("f_c1_we", {31'd0, mem_we}, 32'd0);
    chk("f_c1_gnt", {31'd0, if_gnt}, 32'd0);
    chk("f_c1_stall", {31'd0, stall_f}, 32'd1);
    edgeIn();
    mem_ready = 1'b1;
    settle();
    chk("f_c2_ign_rv", {31'd0, if_rvalid}, 32'd0);
    mem_ready = 1'b0;
    edgeIn();
    mem_ready = 1'b1;
    mem_rdata = 32'h0050_0093;
    settle();
    chk("f_c3_memreq", {31'd0, mem_req}, 32'd1);
    chk("f_c3_stall", {31'd0, stall_f}, 32'd1);
    edgeIn();
    mem_ready = 1'b0;
    if_req    = 1'b0;
    settle();
    chk("f_c4_rvalid", {31'd0, if_rvalid}, 32'd1);
    chk("f_c4_rdata", if_rdata, 32'h0050_0093);
    chk("f_c4_memreq", {31'd0, mem_req}, 32'd0);
    edgeIn();
    settle();
    chk("f_c5_rvalid", {31'd0, if_rvalid}, 32'd0);
    chk("f_c5_ign_gnt", {31'd0, if_gnt}, 32'd0);
    chk("f_c2_ignored", {31'd0, mem_req}, 32'd0);

    // simultaneous requests, memory always ready
    edgeIn();
    mem_ready = 1'b1;
    mem_rdata = 32'h1111_1111;
    if_req    = 1'b1;
    if_addr   = 32'h20;
    dm_req    = 1'b1;
    dm_addr   = 32'h80;
    settle();
    chk("p_c0_dm_gnt", {31'd0, dm_gnt}, 32'd1);
    chk("p_c0_if_gnt", {31'd0, if_gnt}, 32'd0);
    edgeIn();
    settle();
    chk("p_c1_addr", mem_addr, 32'h80);
    chk("p_c1_gnts", {30'd0, if_gnt, dm_gnt}, 32'd0);
    edgeIn();
    dm_req    = 1'b0;
    mem_rdata = 32'h2222_2222;
    settle();
    chk("p_c2_dm_rv", {31'd0, dm_rvalid}, 32'd1);
    chk("p_c2_dm_rd", dm_rdata, 32'h1111_1111);
    chk("p_c2_if_gnt", {31'd0, if_gnt}, 32'd1);
    edgeIn();
    settle();
    chk("p_c3_addr", mem_addr, 32'h20);
    edgeIn();
    if_req = 1'b0;
    settle();
    chk("p_c4_if_rv", {31'd0, if_rvalid}, 32'd1);
    chk("p_c4_if_rd", if_rdata, 32'h2222_2222);

    // starvation window: expect D,D,D,D,I,D
    edgeIn();
    mem_rdata = 32'h3333_3333;
    if_req    = 1'b1;
    dm_req    = 1'b1;
    nG        = 0;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) edgeIn();
      settle();
      if (dm_gnt || if_gnt) begin
        if (nG < 6) grants[nG] = dm_gnt ? "D" : "I";
        nG++;
      end
    end
    chk("s_count", nG, 32'd6);
    chk("s_g0", {24'd0, grants[0]}, 32'h44);
    chk("s_g1", {24'd0, grants[1]}, 32'h44);
    chk("s_g2", {24'd0, grants[2]}, 32'h44);
    chk("s_g3", {24'd0, grants[3]}, 32'h44);
    chk("s_g4", {24'd0, grants[4]}, 32'h49);
    chk("s_g5", {24'd0, grants[5]}, 32'h44);
    edgeIn();
    if_req = 1'b0;
    dm_req = 1'b0;
    settle();
    chk("s_last_rv", {31'd0, dm_rvalid}, 32'd1);

    // store with delayed ready
    edgeIn();
    mem_ready = 1'b0;
    mem_rdata = 32'h5555_AAAA;
    dm_req    = 1'b1;
    dm_we     = 1'b1;
    dm_addr   = 32'h100;
    dm_wdata  = 32'hDEAD_BEEF;
    settle();
    chk("w_c0_gnt", {31'd0, dm_gnt}, 32'd1);
    for (int c = 1; c <= 2; c++) begin
      edgeIn();
      if (c == 2) mem_ready = 1'b1;
      settle();
      chk("w_memreq", {31'd0, mem_req}, 32'd1);
      chk("w_we", {31'd0, mem_we}, 32'd1);
      chk("w_addr", mem_addr, 32'h100);
      chk("w_wdata", mem_wdata, 32'hDEAD_BEEF);
      chk("w_rv_low", {31'd0, dm_rvalid}, 32'd0);
      chk("w_stall_m", {31'd0, stall_m}, 32'd1);
    end
    edgeIn();
    mem_ready = 1'b0;
    dm_req    = 1'b0;
    dm_we     = 1'b0;
    settle();
    chk("w_rv", {31'd0, dm_rvalid}, 32'd1);
    chk("w_rdata_kept", dm_rdata, 32'h3333_3333);
    chk("w_memreq_off", {31'd0, mem_req}, 32'd0);
    edgeIn();
    settle();
    chk("w_rv_single", {31'd0, dm_rvalid}, 32'd0);

    // reset while a load is outstanding
    edgeIn();
    dm_req  = 1'b1;
    dm_addr = 32'h200;
    settle();
    chk("r_c0_gnt", {31'd0, dm_gnt}, 32'd1);
    edgeIn();
    rst = 1'b0;
    settle();
    chk("r_c1_memreq", {31'd0, mem_req}, 32'd1);
    chk("r_c1_stall_m", {31'd0, stall_m}, 32'd0);
    edgeIn();
    rst    = 1'b1;
    dm_req = 1'b0;
    settle();
    chk("r_c2_memreq", {31'd0, mem_req}, 32'd0);
    chk("r_c2_rv", {31'd0, dm_rvalid}, 32'd0);
    chk("r_c2_rdata", dm_rdata, 32'd0);
    edgeIn();
    dm_req    = 1'b1;
    dm_addr   = 32'h204;
    mem_ready = 1'b1;
    settle();
    chk("r_c3_rv", {31'd0, dm_rvalid}, 32'd0);
    chk("r_c3_idle_gnt", {31'd0, dm_gnt}, 32'd1);
    edgeIn();
    dm_req = 1'b0;
    settle();
    chk("r_c4_addr", mem_addr, 32'h204);
    edgeIn();
    settle();
    chk("r_c5_rv", {31'd0, dm_rvalid}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
